// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the dataMemory two-port access controller.
package dm_arb_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester-side handshake for one dataMemory port: req/we/addr/wdata out, ack/rdata back.
interface dm_arbiter_if;
    import dm_arb_pkg::*;

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);

endinterface

// File: rtl/dm_arb_starve_ctr.sv
// Saturating wait counter for the low-priority port; at_limit forces its grant.
module dm_arb_starve_ctr #(
    parameter  int STARVE_LIMIT = 8,
    localparam int CW           = $clog2(STARVE_LIMIT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic          at_limit,
    output logic [CW-1:0] cnt
);

    assign at_limit = (cnt == CW'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_limit) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single dataMemory port between the CPU (port 0, fixed priority)
// and a DMA/debug master (port 1); every access is IDLE -> ACCESS -> DONE.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    dm_arbiter_if.slave       p0,
    dm_arbiter_if.slave       p1,
    output logic [ADDR_W-1:0] A_DataAddress,
    output logic [DATA_W-1:0] D_WriteData,
    output logic              C_DMRead,
    output logic              C_DMWrite,
    input  logic [DATA_W-1:0] D_Data,
    output logic              busy
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    state_t            state, state_nxt;
    logic              owner;
    logic              we_q;
    logic              grant0, grant1;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic              at_limit;
    logic              starve_inc;
    logic [CW-1:0]     starve_cnt;

    always_comb begin
        state_nxt = state;
        grant0    = 1'b0;
        grant1    = 1'b0;
        case (state)
            IDLE: begin
                if (p1.req && (at_limit || !p0.req)) begin
                    grant1    = 1'b1;
                    state_nxt = ACCESS;
                end else if (p0.req) begin
                    grant0    = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sel_we    = grant1 ? p1.we    : p0.we;
        sel_addr  = grant1 ? p1.addr  : p0.addr;
        sel_wdata = grant1 ? p1.wdata : p0.wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Address and write data double as the owner's latched request; strobes qualify them.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner         <= PORT_CPU;
            we_q          <= 1'b0;
            A_DataAddress <= '0;
            D_WriteData   <= '0;
            C_DMRead      <= 1'b0;
            C_DMWrite     <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
        end else begin
            if (grant0 || grant1) begin
                owner         <= grant1 ? PORT_DMA : PORT_CPU;
                we_q          <= sel_we;
                A_DataAddress <= sel_addr;
                D_WriteData   <= sel_wdata;
                C_DMWrite     <= sel_we;
                C_DMRead      <= !sel_we;
            end
            if (state == ACCESS) begin
                C_DMRead  <= 1'b0;
                C_DMWrite <= 1'b0;
                if (!we_q) begin
                    if (owner == PORT_DMA) begin
                        rdata1_q <= D_Data;
                    end else begin
                        rdata0_q <= D_Data;
                    end
                end
            end
        end
    end

    // Port 1 stops aging only while it owns the memory.
    assign starve_inc = p1.req && !grant1 && !((state != IDLE) && (owner == PORT_DMA));

    dm_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .inc      (starve_inc),
        .clr      (grant1),
        .at_limit (at_limit),
        .cnt      (starve_cnt)
    );

    assign p0.ack   = (state == DONE) && (owner == PORT_CPU);
    assign p1.ack   = (state == DONE) && (owner == PORT_DMA);
    assign p0.rdata = rdata0_q;
    assign p1.rdata = rdata1_q;
    assign busy     = (state != IDLE);

endmodule
